motors_cmd_master: RTL and testbench

- Initiator (master) end of the MotorsCtrl command interface. Drives pulse_num_x, pulse_num_y, servo_pos and trigger, and tracks rdy.
- Accepts relative move commands from the upstream processor over a valid/ready handshake. Each command is dx, dy and a pen (servo) position.
- Splits each command into downstream transactions: an optional servo-only transaction first, then moves clamped to ±MAX_STEP per axis.
- Issues each transaction to MotorsCtrl and waits for completion before issuing the next.

---
 rtl/motors_cmd_master.sv | 213 +++++++++++++++++++++
 tb/tb_motors_cmd_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motors_cmd_master.sv
// motors_cmd_master
// Initiator end of the MotorsCtrl command interface. Takes relative move
// commands (dx, dy, pen position) from upstream and issues them to MotorsCtrl
// as a sequence of downstream transactions: a servo-only transaction first if
// the pen position changes, then moves of at most MAX_STEP pulses per axis.
// Each transaction is completed (rdy back high) before the next is issued.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   clk_en              state advances only on clk edges with clk_en=1
//   cmd_valid/cmd_ready upstream command handshake
//   cmd_dx, cmd_dy      signed relative move (CMD_W bits)
//   cmd_servo           requested servo position
//   pulse_num_x/_y      signed pulses of the current transaction (PULSE_W bits)
//   servo_pos           servo position of the current transaction
//   trigger             transaction request to MotorsCtrl
//   rdy                 MotorsCtrl ready: high = idle/done, falling = accepted
//   busy                command in progress (state other than IDLE)
//   error, clear_err    sticky ack-timeout flag and its synchronous clear
//   dbg_state           current FSM state (debug visibility)
//
// Handshakes
//   Upstream: a command transfers on a clk_en edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is registered and falls on that same
//   edge; upstream must hold the command stable until the transfer.
//   Downstream: trigger rises with pulse/servo data already stable, stays
//   high until rdy is seen low (accepted) and the data is held unchanged
//   while trigger is high. The next transaction waits for rdy to return high.
module motors_cmd_master #(
    parameter int CMD_W       = 20,
    parameter int PULSE_W     = 16,
    parameter int MAX_STEP    = 1023,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_W-1:0]   cmd_dx,
    input  logic [CMD_W-1:0]   cmd_dy,
    input  logic               cmd_servo,
    output logic [PULSE_W-1:0] pulse_num_x,
    output logic [PULSE_W-1:0] pulse_num_y,
    output logic               servo_pos,
    output logic               trigger,
    input  logic               rdy,
    output logic               busy,
    output logic               error,
    input  logic               clear_err,
    output logic [2:0]         dbg_state
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic SERVO_POS_UP = 1'b0;

    // Clamp limits: comparison is done sign-extended to CMD_W+1 bits.
    localparam logic signed [CMD_W:0]   STEP_POS_W = (CMD_W+1)'(MAX_STEP);
    localparam logic signed [CMD_W:0]   STEP_NEG_W = (CMD_W+1)'(-MAX_STEP);
    localparam logic signed [CMD_W-1:0] STEP_C     = CMD_W'(MAX_STEP);
    localparam logic [PULSE_W-1:0]      PULSE_POS  = PULSE_W'(MAX_STEP);
    localparam logic [PULSE_W-1:0]      PULSE_NEG  = PULSE_W'(-MAX_STEP);
    localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAN      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic signed [CMD_W-1:0]  rem_x, rem_y, rem_x_nxt, rem_y_nxt;
    logic                     req_servo, req_servo_nxt;
    logic                     cur_servo, cur_servo_nxt;
    logic [PULSE_W-1:0]       px_nxt, py_nxt;
    logic                     servo_nxt, trig_nxt, err_nxt, ready_nxt;
    logic [CNT_W-1:0]         ack_cnt, cnt_nxt;
    logic                     timeout;

    // Per-axis chunk selection. When |rem| <= MAX_STEP the whole remainder
    // is issued, so its low PULSE_W bits are the chunk and rem goes to zero.
    logic signed [CMD_W:0]    rem_x_w, rem_y_w;
    logic                     x_hi, x_lo, y_hi, y_lo;
    logic [PULSE_W-1:0]       chunk_x, chunk_y;
    logic signed [CMD_W-1:0]  left_x, left_y;

    assign rem_x_w = {rem_x[CMD_W-1], rem_x};
    assign rem_y_w = {rem_y[CMD_W-1], rem_y};
    assign x_hi    = rem_x_w > STEP_POS_W;
    assign x_lo    = rem_x_w < STEP_NEG_W;
    assign y_hi    = rem_y_w > STEP_POS_W;
    assign y_lo    = rem_y_w < STEP_NEG_W;
    assign chunk_x = x_hi ? PULSE_POS : (x_lo ? PULSE_NEG : rem_x[PULSE_W-1:0]);
    assign chunk_y = y_hi ? PULSE_POS : (y_lo ? PULSE_NEG : rem_y[PULSE_W-1:0]);
    assign left_x  = x_hi ? (rem_x - STEP_C) : (x_lo ? (rem_x + STEP_C) : '0);
    assign left_y  = y_hi ? (rem_y - STEP_C) : (y_lo ? (rem_y + STEP_C) : '0);

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rem_x_nxt     = rem_x;
        rem_y_nxt     = rem_y;
        req_servo_nxt = req_servo;
        cur_servo_nxt = cur_servo;
        px_nxt        = pulse_num_x;
        py_nxt        = pulse_num_y;
        servo_nxt     = servo_pos;
        trig_nxt      = trigger;
        cnt_nxt       = ack_cnt;
        timeout       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rem_x_nxt     = $signed(cmd_dx);
                    rem_y_nxt     = $signed(cmd_dy);
                    req_servo_nxt = cmd_servo;
                    state_nxt     = ST_PLAN;
                end
            end
            ST_PLAN: begin
                if (req_servo != cur_servo) begin
                    px_nxt        = '0;
                    py_nxt        = '0;
                    servo_nxt     = req_servo;
                    cur_servo_nxt = req_servo;
                    trig_nxt      = 1'b1;
                    state_nxt     = ST_REQ;
                end else if ((rem_x != '0) || (rem_y != '0)) begin
                    px_nxt    = chunk_x;
                    py_nxt    = chunk_y;
                    servo_nxt = cur_servo;
                    rem_x_nxt = left_x;
                    rem_y_nxt = left_y;
                    trig_nxt  = 1'b1;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!rdy) begin
                    trig_nxt  = 1'b0;
                    state_nxt = ST_WAIT_DONE;
                end else if (ack_cnt == CNT_LAST) begin
                    // MotorsCtrl never accepted: abandon the rest of the command.
                    timeout   = 1'b1;
                    trig_nxt  = 1'b0;
                    rem_x_nxt = '0;
                    rem_y_nxt = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = ack_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (rdy) begin
                    state_nxt = ST_PLAN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A timeout on the same edge as clear_err leaves the flag set.
        err_nxt   = timeout ? 1'b1 : (clear_err ? 1'b0 : error);
        ready_nxt = (state_nxt == ST_IDLE) && rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_x       <= '0;
            rem_y       <= '0;
            req_servo   <= SERVO_POS_UP;
            cur_servo   <= SERVO_POS_UP;
            pulse_num_x <= '0;
            pulse_num_y <= '0;
            servo_pos   <= SERVO_POS_UP;
            trigger     <= 1'b0;
            ack_cnt     <= '0;
            error       <= 1'b0;
            cmd_ready   <= 1'b0;
        end else if (clk_en) begin
            rem_x       <= rem_x_nxt;
            rem_y       <= rem_y_nxt;
            req_servo   <= req_servo_nxt;
            cur_servo   <= cur_servo_nxt;
            pulse_num_x <= px_nxt;
            pulse_num_y <= py_nxt;
            servo_pos   <= servo_nxt;
            trigger     <= trig_nxt;
            ack_cnt     <= cnt_nxt;
            error       <= err_nxt;
            cmd_ready   <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_motors_cmd_master.sv
// tb_motors_cmd_master
// Directed plus randomized bench for motors_cmd_master with a MotorsCtrl-like
// slave. Expected downstream transactions come from a reference model that
// splits each command with plain integer arithmetic.
module tb_motors_cmd_master;

    localparam int CMD_W       = 20;
    localparam int PULSE_W     = 16;
    localparam int MAX_STEP    = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int TW          = 2 * PULSE_W + 1;
    localparam logic UP        = 1'b0;
    localparam logic DOWN      = 1'b1;

    // ---------------- clock / reset / DUT ----------------
    logic               clk;
    logic               reset;
    logic               clk_en;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CMD_W-1:0]   cmd_dx;
    logic [CMD_W-1:0]   cmd_dy;
    logic               cmd_servo;
    logic [PULSE_W-1:0] pulse_num_x;
    logic [PULSE_W-1:0] pulse_num_y;
    logic               servo_pos;
    logic               trigger;
    logic               rdy;
    logic               busy;
    logic               error;
    logic               clear_err;
    logic [2:0]         dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    motors_cmd_master #(
        .CMD_W(CMD_W), .PULSE_W(PULSE_W), .MAX_STEP(MAX_STEP), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_servo(cmd_servo),
        .pulse_num_x(pulse_num_x), .pulse_num_y(pulse_num_y), .servo_pos(servo_pos),
        .trigger(trigger), .rdy(rdy), .busy(busy), .error(error),
        .clear_err(clear_err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] obs_q[$];
    logic m_servo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] pack(input int x, input int y, input logic s);
        logic [PULSE_W-1:0] xx;
        logic [PULSE_W-1:0] yy;
        xx = PULSE_W'(x);
        yy = PULSE_W'(y);
        return {xx, yy, s};
    endfunction

    function automatic int clampi(input int v);
        if (v > MAX_STEP) return MAX_STEP;
        if (v < -MAX_STEP) return -MAX_STEP;
        return v;
    endfunction

    // Reference: servo change first, then clamped chunks until both axes are 0.
    task automatic model_cmd(input int dx, input int dy, input logic s);
        int rx, ry, cx, cy;
        if (s != m_servo) begin
            exp_q.push_back(pack(0, 0, s));
            m_servo = s;
        end
        rx = dx;
        ry = dy;
        while (rx != 0 || ry != 0) begin
            cx = clampi(rx);
            cy = clampi(ry);
            exp_q.push_back(pack(cx, cy, m_servo));
            rx -= cx;
            ry -= cy;
        end
    endtask

    task automatic check_txns(input string tag);
        int n;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_txn"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- slave model and clk_en generator ----------------
    // Slave registers trigger on an enabled edge, then drops rdy; once trigger
    // falls it stays busy for a few enabled edges and raises rdy again.
    int        s_state    = 0;
    bit        slave_mute = 0;
    bit        hold_long  = 0;
    int        en_mode    = 0;
    int        en_phase   = 0;
    int        busy_left  = 0;
    int        edges_since = 0;
    int        trig_cnt   = 0;
    logic      edge_en;
    logic      prev_trig  = 1'b0;
    logic      prev_rst   = 1'b0;
    logic [TW-1:0] held_data;
    logic [TW-1:0] cur_data;
    logic [39:0]   snap, prev_snap;

    assign cur_data = {pulse_num_x, pulse_num_y, servo_pos};
    assign snap     = {cmd_ready, pulse_num_x, pulse_num_y, servo_pos, trigger, busy, error, dbg_state};

    always begin
        @(posedge clk);
        #2;
        edge_en = clk_en;
        if (!reset) begin
            s_state   = 0;
            rdy       = 1'b1;
            prev_trig = 1'b0;
        end else begin
            if (!edge_en && prev_rst) chk("hold_when_en_low", 64'(snap), 64'(prev_snap));
            if (trigger && !prev_trig) begin
                obs_q.push_back(cur_data);
                held_data = cur_data;
                trig_cnt  = 0;
            end else if (prev_trig && edge_en) begin
                trig_cnt++;
            end
            if (trigger && prev_trig) chk("data_stable", 64'(cur_data), 64'(held_data));
            prev_trig = trigger;
            case (s_state)
                0: if (trigger && !slave_mute) s_state = 1;
                1: if (edge_en) begin
                    rdy = 1'b0;
                    edges_since = 0;
                    s_state = 2;
                end
                2: if (!trigger) begin
                    chk("trig_drop_1edge", 64'(edges_since), 64'(0));
                    busy_left = hold_long ? 30 : int'($urandom_range(1, 3));
                    s_state = 3;
                end else if (edge_en) begin
                    edges_since++;
                end
                3: if (edge_en) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        rdy = 1'b1;
                        s_state = 0;
                    end
                end
                default: s_state = 0;
            endcase
        end
        prev_snap = snap;
        prev_rst  = reset;
        if (en_mode == 0) begin
            clk_en = 1'b1;
        end else begin
            en_phase = (en_phase + 1) % 3;
            clk_en = (en_phase == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_cmd(input int dx, input int dy, input logic s);
        bit acc;
        acc = 0;
        @(negedge clk);
        cmd_dx    = CMD_W'(dx);
        cmd_dy    = CMD_W'(dy);
        cmd_servo = s;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready && clk_en) begin
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 64'(acc), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy && cmd_ready && s_state == 0) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_idle"}, 64'(ok), 64'(1));
    endtask

    task automatic wait_trig(input logic lvl, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (trigger === lvl) begin
                ok = 1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trigger"}, 64'(trigger), 64'(0));
        chk({tag, "_px"}, 64'(pulse_num_x), 64'(0));
        chk({tag, "_py"}, 64'(pulse_num_y), 64'(0));
        chk({tag, "_servo"}, 64'(servo_pos), 64'(UP));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_error"}, 64'(error), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0; cmd_dx = '0; cmd_dy = '0;
        cmd_servo = UP; rdy = 1'b1; clear_err = 1'b0; m_servo = UP;
        #1 reset = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // servo change then a small move
        model_cmd(-3, 2, DOWN);
        do_cmd(-3, 2, DOWN);
        wait_idle("cmd1");
        check_txns("cmd1");

        // servo back up with an X move needing two chunks
        model_cmd(5, 1, UP);
        do_cmd(5, 1, UP);
        wait_idle("cmd2");
        check_txns("cmd2");

        // opposite-sign axes, three chunks, servo unchanged
        model_cmd(-9, 9, UP);
        do_cmd(-9, 9, UP);
        wait_idle("cmd3");
        check_txns("cmd3");

        // zero move: no transaction, busy for a single cycle
        do_cmd(0, 0, UP);
        chk("zero_busy_high", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        chk("zero_busy_low", 64'(busy), 64'(0));
        chk("zero_ready", 64'(cmd_ready), 64'(1));
        check_txns("zero");

        // ack timeout: slave never drops rdy
        slave_mute = 1;
        model_cmd(2, 0, UP);
        do_cmd(2, 0, UP);
        wait_trig(1'b1, "to1_rise");
        wait_trig(1'b0, "to1_fall");
        chk("to1_error", 64'(error), 64'(1));
        chk("to1_state", 64'(dbg_state), 64'(0));
        chk("to1_busy", 64'(busy), 64'(0));
        chk("to1_len", 64'(trig_cnt == ACK_TIMEOUT || trig_cnt == ACK_TIMEOUT + 1), 64'(1));
        wait_idle("to1");
        chk("to1_sticky", 64'(error), 64'(1));
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1 chk("clear_err", 64'(error), 64'(0));

        // timeout with clear_err held: timeout edge wins
        model_cmd(-1, 0, UP);
        do_cmd(-1, 0, UP);
        wait_trig(1'b1, "to2_rise");
        wait_trig(1'b0, "to2_fall");
        chk("to2_timeout_wins", 64'(error), 64'(1));
        @(posedge clk);
        #1 chk("to2_cleared", 64'(error), 64'(0));
        @(negedge clk);
        clear_err = 1'b0;
        slave_mute = 0;
        wait_idle("to2");
        check_txns("timeout");

        // reset during WAIT_DONE of a multi-chunk command
        hold_long = 1;
        do_cmd(9, 0, DOWN);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 500; i++) begin
                @(posedge clk);
                #1;
                if (obs_q.size() == 2 && dbg_state == 3'd4) begin
                    ok = 1;
                    break;
                end
            end
            chk("rst_reach_wait_done", 64'(ok), 64'(1));
        end
        chk("pre_rst_px", 64'(pulse_num_x), 64'(4));
        chk("pre_rst_servo", 64'(servo_pos), 64'(DOWN));
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        obs_q.delete();
        exp_q.delete();
        m_servo   = UP;
        hold_long = 0;
        @(negedge clk);
        reset = 1'b1;
        model_cmd(1, 1, DOWN);
        do_cmd(1, 1, DOWN);
        wait_idle("post_rst");
        check_txns("post_rst");

        // clk_en at 1-in-3 with the servo-up / two-chunk command
        en_mode = 1;
        model_cmd(5, 1, UP);
        do_cmd(5, 1, UP);
        wait_idle("slow_en");
        check_txns("slow_en");

        // randomized commands with random clk_en mode
        for (int k = 0; k < 8; k++) begin
            int dx, dy;
            logic s;
            dx = int'($urandom_range(0, 24)) - 12;
            dy = int'($urandom_range(0, 24)) - 12;
            s  = 1'($urandom_range(0, 1));
            en_mode = int'($urandom_range(0, 1));
            model_cmd(dx, dy, s);
            do_cmd(dx, dy, s);
            wait_idle("rand");
            check_txns("rand");
        end
        chk("final_error", 64'(error), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
